// File: rtl/axi_mem_resp.sv
// AXI4 memory responder backed by byte-lane block RAM.
// Independent write and read FSMs, one outstanding burst per direction,
// INCR bursts that wrap modulo the memory depth. Burst counters are
// readable and clearable over the SoftReg bus.
module axi_mem_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] SR_ADDR    = 32'h20
) (
    input  logic          clk,
    input  logic          rst,
    // SoftReg request / response
    input  logic          sr_req_valid,
    input  logic          sr_req_is_write,
    input  logic [31:0]   sr_req_addr,
    input  logic [63:0]   sr_req_data,
    output logic          sr_resp_valid,
    output logic [63:0]   sr_resp_data,
    // AXI write address
    input  logic          axi_awvalid,
    output logic          axi_awready,
    input  logic [15:0]   axi_awid,
    input  logic [63:0]   axi_awaddr,
    input  logic [7:0]    axi_awlen,
    input  logic [2:0]    axi_awsize,
    input  logic [1:0]    axi_awburst,
    // AXI write data
    input  logic          axi_wvalid,
    output logic          axi_wready,
    input  logic [511:0]  axi_wdata,
    input  logic [63:0]   axi_wstrb,
    input  logic          axi_wlast,
    // AXI write response
    output logic          axi_bvalid,
    input  logic          axi_bready,
    output logic [15:0]   axi_bid,
    output logic [1:0]    axi_bresp,
    // AXI read address
    input  logic          axi_arvalid,
    output logic          axi_arready,
    input  logic [15:0]   axi_arid,
    input  logic [63:0]   axi_araddr,
    input  logic [7:0]    axi_arlen,
    input  logic [2:0]    axi_arsize,
    input  logic [1:0]    axi_arburst,
    // AXI read data
    output logic          axi_rvalid,
    input  logic          axi_rready,
    output logic [15:0]   axi_rid,
    output logic [511:0]  axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          axi_rlast
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rd_state_t;

    // Size, burst type, wlast, the SoftReg write payload and the address
    // bits outside the word index carry no information for this endpoint.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awaddr[63:6+DEPTH_LOG2], axi_awaddr[5:0],
                             axi_araddr[63:6+DEPTH_LOG2], axi_araddr[5:0],
                             axi_awsize, axi_awburst, axi_arsize, axi_arburst,
                             axi_wlast, sr_req_data};

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    wr_state_t               wr_state_reg;
    logic                    awready_reg;
    logic                    wready_reg;
    logic                    bvalid_reg;
    logic [15:0]             bid_reg;
    logic [DEPTH_LOG2-1:0]   wr_idx_reg;
    logic [7:0]              wr_len_reg;
    logic [7:0]              wr_beat_reg;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    rd_state_t               rd_state_reg;
    logic                    arready_reg;
    logic                    rvalid_reg;
    logic                    rlast_reg;
    logic [15:0]             rid_reg;
    logic [DEPTH_LOG2-1:0]   rd_idx_reg;
    logic [7:0]              rd_len_reg;
    logic [7:0]              rd_beat_reg;

    logic [63:0]             wr_count_reg;
    logic [63:0]             rd_count_reg;
    logic                    sr_resp_valid_reg;
    logic [63:0]             sr_resp_data_reg;

    logic                    mem_we;
    logic                    mem_re;
    logic                    wr_done;
    logic                    rd_done;
    logic                    sr_clear;
    logic [511:0]            rdata_bus;

    // A beat presented while reset is asserted is abandoned, not written.
    assign mem_we   = (wr_state_reg == W_DATA) && axi_wvalid && wready_reg && !rst;
    assign mem_re   = (rd_state_reg == R_LOAD);
    assign wr_done  = (wr_state_reg == W_RESP) && axi_bready;
    assign rd_done  = (rd_state_reg == R_DATA) && axi_rready && (rd_beat_reg == rd_len_reg);
    assign sr_clear = sr_req_valid && sr_req_is_write && (sr_req_addr == SR_ADDR);

    // Write FSM: accept AW, absorb len+1 beats, then hold B until bready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bid_reg      <= '0;
            wr_idx_reg   <= '0;
            wr_len_reg   <= '0;
            wr_beat_reg  <= '0;
        end else begin
            case (wr_state_reg)
                W_IDLE: begin
                    awready_reg <= 1'b1;
                    if (axi_awvalid && awready_reg) begin
                        bid_reg      <= axi_awid;
                        wr_idx_reg   <= axi_awaddr[6+DEPTH_LOG2-1:6];
                        wr_len_reg   <= axi_awlen;
                        wr_beat_reg  <= '0;
                        awready_reg  <= 1'b0;
                        wready_reg   <= 1'b1;
                        wr_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid && wready_reg) begin
                        wr_idx_reg  <= wr_idx_reg + 1'b1;
                        wr_beat_reg <= wr_beat_reg + 8'd1;
                        // beat count from len decides the end, not wlast
                        if (wr_beat_reg == wr_len_reg) begin
                            wready_reg   <= 1'b0;
                            bvalid_reg   <= 1'b1;
                            wr_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_reg   <= 1'b0;
                        awready_reg  <= 1'b1;
                        wr_state_reg <= W_IDLE;
                    end
                end
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept AR, then alternate BRAM load and R presentation per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_reg <= R_IDLE;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rid_reg      <= '0;
            rd_idx_reg   <= '0;
            rd_len_reg   <= '0;
            rd_beat_reg  <= '0;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    arready_reg <= 1'b1;
                    if (axi_arvalid && arready_reg) begin
                        rid_reg      <= axi_arid;
                        rd_idx_reg   <= axi_araddr[6+DEPTH_LOG2-1:6];
                        rd_len_reg   <= axi_arlen;
                        rd_beat_reg  <= '0;
                        arready_reg  <= 1'b0;
                        rd_state_reg <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    rvalid_reg   <= 1'b1;
                    rlast_reg    <= (rd_beat_reg == rd_len_reg);
                    rd_state_reg <= R_DATA;
                end
                R_DATA: begin
                    if (axi_rready) begin
                        rvalid_reg <= 1'b0;
                        rlast_reg  <= 1'b0;
                        if (rd_beat_reg == rd_len_reg) begin
                            arready_reg  <= 1'b1;
                            rd_state_reg <= R_IDLE;
                        end else begin
                            rd_idx_reg   <= rd_idx_reg + 1'b1;
                            rd_beat_reg  <= rd_beat_reg + 8'd1;
                            rd_state_reg <= R_LOAD;
                        end
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    // One independent RAM column per byte lane so wstrb maps to a lane enable.
    // The read register only loads in R_LOAD, so rdata holds while stalled, and
    // a same-cycle write to the same word is seen as old data (read-first).
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rdata_reg;

            // Byte-lane write, gated by its strobe bit
            always_ff @(posedge clk) begin
                if (mem_we && axi_wstrb[gi]) begin
                    lane_mem[wr_idx_reg] <= axi_wdata[gi*8 +: 8];
                end
            end

            // Registered byte-lane read
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_rdata_reg <= '0;
                end else if (mem_re) begin
                    lane_rdata_reg <= lane_mem[rd_idx_reg];
                end
            end

            assign rdata_bus[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate

    // Burst counters; a SoftReg clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_reg <= '0;
            rd_count_reg <= '0;
        end else if (sr_clear) begin
            wr_count_reg <= '0;
            rd_count_reg <= '0;
        end else begin
            if (wr_done) begin
                wr_count_reg <= wr_count_reg + 64'd1;
            end
            if (rd_done) begin
                rd_count_reg <= rd_count_reg + 64'd1;
            end
        end
    end

    // SoftReg read response, one cycle after the request; unknown addresses are silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_resp_valid_reg <= 1'b0;
            sr_resp_data_reg  <= '0;
        end else begin
            sr_resp_valid_reg <= 1'b0;
            if (sr_req_valid && !sr_req_is_write) begin
                if (sr_req_addr == SR_ADDR) begin
                    sr_resp_valid_reg <= 1'b1;
                    sr_resp_data_reg  <= wr_count_reg;
                end else if (sr_req_addr == SR_ADDR + 32'd8) begin
                    sr_resp_valid_reg <= 1'b1;
                    sr_resp_data_reg  <= rd_count_reg;
                end
            end
        end
    end

    assign axi_awready   = awready_reg;
    assign axi_wready    = wready_reg;
    assign axi_bvalid    = bvalid_reg;
    assign axi_bid       = bid_reg;
    assign axi_bresp     = 2'b00;
    assign axi_arready   = arready_reg;
    assign axi_rvalid    = rvalid_reg;
    assign axi_rid       = rid_reg;
    assign axi_rdata     = rdata_bus;
    assign axi_rresp     = 2'b00;
    assign axi_rlast     = rlast_reg;
    assign sr_resp_valid = sr_resp_valid_reg;
    assign sr_resp_data  = sr_resp_data_reg;

endmodule

// File: tb/tb_axi_mem_resp.sv
// Directed bench for axi_mem_resp: a word-level memory model plus expected
// B/R queues, checked every cycle by a monitor thread, with literal pins.
module tb_axi_mem_resp;

    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          sr_req_valid, sr_req_is_write;
    logic [31:0]   sr_req_addr;
    logic [63:0]   sr_req_data;
    logic          sr_resp_valid;
    logic [63:0]   sr_resp_data;
    logic          axi_awvalid, axi_awready;
    logic [15:0]   axi_awid;
    logic [63:0]   axi_awaddr;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic          axi_wvalid, axi_wready;
    logic [511:0]  axi_wdata;
    logic [63:0]   axi_wstrb;
    logic          axi_wlast;
    logic          axi_bvalid, axi_bready;
    logic [15:0]   axi_bid;
    logic [1:0]    axi_bresp;
    logic          axi_arvalid, axi_arready;
    logic [15:0]   axi_arid;
    logic [63:0]   axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_rvalid, axi_rready;
    logic [15:0]   axi_rid;
    logic [511:0]  axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;

    axi_mem_resp #(.DEPTH_LOG2(10), .SR_ADDR(32'h20)) dut (
        .clk(clk), .rst(rst),
        .sr_req_valid(sr_req_valid), .sr_req_is_write(sr_req_is_write),
        .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
        .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    int            pass_cnt = 0;
    int            total_cnt = 0;
    bit            mon_en = 1'b0;
    logic [511:0]  model_mem [DEPTH];
    longint        model_wr_bursts = 0;
    longint        model_rd_bursts = 0;
    logic [511:0]  exp_r_data[$];
    logic [15:0]   exp_r_id[$];
    logic          exp_r_last[$];
    logic [15:0]   exp_b_id[$];
    logic [511:0]  wbeat_data [16];
    logic [63:0]   wbeat_strb [16];
    logic [511:0]  got_r [16];

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    function automatic void model_write(input int idx, input logic [511:0] d, input logic [63:0] s);
        for (int i = 0; i < 64; i++)
            if (s[i]) model_mem[idx][i*8 +: 8] = d[i*8 +: 8];
    endfunction

    // Per-cycle comparison of R and B channels against the expected queues
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                if (axi_rvalid) begin
                    if (exp_r_data.size() == 0) check("r_unexpected", 1'b1, 1'b0);
                    else begin
                        check("r_data", axi_rdata, exp_r_data[0]);
                        check("r_id", axi_rid, exp_r_id[0]);
                        check("r_last", axi_rlast, exp_r_last[0]);
                        check("r_resp", axi_rresp, 2'b00);
                        if (axi_rready) begin
                            void'(exp_r_data.pop_front());
                            void'(exp_r_id.pop_front());
                            void'(exp_r_last.pop_front());
                        end
                    end
                end
                if (axi_bvalid) begin
                    if (exp_b_id.size() == 0) check("b_unexpected", 1'b1, 1'b0);
                    else begin
                        check("b_id", axi_bid, exp_b_id[0]);
                        check("b_resp", axi_bresp, 2'b00);
                        if (axi_bready) void'(exp_b_id.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, axi_awready, 1'b0);
        check({tag, "_wready"}, axi_wready, 1'b0);
        check({tag, "_arready"}, axi_arready, 1'b0);
        check({tag, "_bvalid"}, axi_bvalid, 1'b0);
        check({tag, "_rvalid"}, axi_rvalid, 1'b0);
        check({tag, "_rlast"}, axi_rlast, 1'b0);
        check({tag, "_sr_valid"}, sr_resp_valid, 1'b0);
        check({tag, "_bid"}, axi_bid, 16'h0);
        check({tag, "_rid"}, axi_rid, 16'h0);
        check({tag, "_rdata"}, axi_rdata, 512'h0);
    endtask

    // Write burst from wbeat_data/wbeat_strb; abort_at >= 0 pulses reset on that beat
    task automatic axi_write(input logic [63:0] addr, input logic [15:0] id, input int len,
                             input int bstall, input int abort_at);
        int idx, beat, cyc, stall_left;
        idx = int'(addr[15:6]);
        @(posedge clk); #1;
        axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(len);
        stall_left = bstall;
        axi_bready = (bstall > 0) ? 1'b0 : 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!axi_awready && cyc < 50) begin cyc++; @(negedge clk); end
        if (!axi_awready) begin
            check("aw_timeout", 1'b0, 1'b1);
            axi_awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        beat = 0; cyc = 0;
        axi_wvalid = 1'b1; axi_wdata = wbeat_data[0]; axi_wstrb = wbeat_strb[0];
        while (beat <= len) begin
            @(negedge clk);
            if (axi_wready) begin
                model_write((idx + beat) % DEPTH, axi_wdata, axi_wstrb);
                if (beat == len) exp_b_id.push_back(id);
                beat++;
            end
            @(posedge clk); #1;
            if (beat <= len) begin
                axi_wdata = wbeat_data[beat]; axi_wstrb = wbeat_strb[beat];
                if (beat == abort_at) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0; axi_wvalid = 1'b0;
                    model_wr_bursts = 0; model_rd_bursts = 0;
                    @(negedge clk);
                    check_reset_outputs("midrst");
                    @(negedge clk);
                    check("midrst_no_b", axi_bvalid, 1'b0);
                    return;
                end
            end else axi_wvalid = 1'b0;
            if (++cyc > 200) begin
                check("w_timeout", 1'b0, 1'b1);
                axi_wvalid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check("b_latency", axi_bvalid, 1'b1);
        cyc = 0;
        while (1) begin
            if (axi_bvalid && axi_bready) begin
                model_wr_bursts++;
                @(posedge clk); #1;
                axi_bready = 1'b0;
                break;
            end
            if (!axi_bready) begin
                check("b_stall_bvalid", axi_bvalid, 1'b1);
                check("b_stall_awready", axi_awready, 1'b0);
                stall_left--;
            end
            @(posedge clk); #1;
            axi_bready = (stall_left > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (++cyc > 50) begin check("b_timeout", 1'b0, 1'b1); break; end
        end
    endtask

    // Read burst; rready is dropped for stall_cycles starting at beat stall_beat
    task automatic axi_read(input logic [63:0] addr, input logic [15:0] id, input int len,
                            input int stall_beat, input int stall_cycles);
        int idx, beats, cyc, stall_left;
        idx = int'(addr[15:6]);
        for (int b = 0; b <= len; b++) begin
            exp_r_data.push_back(model_mem[(idx + b) % DEPTH]);
            exp_r_id.push_back(id);
            exp_r_last.push_back(b == len);
        end
        beats = 0; stall_left = stall_cycles;
        @(posedge clk); #1;
        axi_rready = (stall_beat == 0 && stall_left > 0) ? 1'b0 : 1'b1;
        axi_arvalid = 1'b1; axi_arid = id; axi_araddr = addr; axi_arlen = 8'(len);
        cyc = 0;
        @(negedge clk);
        while (!axi_arready && cyc < 50) begin cyc++; @(negedge clk); end
        if (!axi_arready) begin
            check("ar_timeout", 1'b0, 1'b1);
            axi_arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        @(negedge clk);
        check("r_lat_load", axi_rvalid, 1'b0);
        @(negedge clk);
        check("r_lat_first", axi_rvalid, 1'b1);
        cyc = 0;
        while (1) begin
            if (axi_rvalid && axi_rready) begin
                got_r[beats] = axi_rdata;
                beats++;
            end
            if (!axi_rready) begin
                check("r_stall_arready", axi_arready, 1'b0);
                stall_left--;
            end
            @(posedge clk); #1;
            if (beats > len) begin axi_rready = 1'b0; break; end
            axi_rready = (beats == stall_beat && stall_left > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (++cyc > 500) begin check("r_timeout", 1'b0, 1'b1); break; end
        end
        if (beats > len) model_rd_bursts++;
    endtask

    task automatic sr_write(input logic [31:0] addr);
        @(posedge clk); #1;
        sr_req_valid = 1'b1; sr_req_is_write = 1'b1; sr_req_addr = addr; sr_req_data = 64'h1234;
        @(posedge clk); #1;
        sr_req_valid = 1'b0; sr_req_is_write = 1'b0;
    endtask

    task automatic sr_read(input string name, input logic [31:0] addr, input bit has_resp,
                           input logic [63:0] exp);
        @(posedge clk); #1;
        sr_req_valid = 1'b1; sr_req_is_write = 1'b0; sr_req_addr = addr;
        @(negedge clk);
        check({name, "_early"}, sr_resp_valid, 1'b0);
        @(posedge clk); #1;
        sr_req_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, sr_resp_valid, has_resp);
        if (has_resp) check({name, "_data"}, sr_resp_data, exp);
        @(negedge clk);
        check({name, "_one_cycle"}, sr_resp_valid, 1'b0);
    endtask

    function automatic void fill_beats(input logic [7:0] first, input logic [63:0] strb);
        logic [7:0] b;
        for (int k = 0; k < 16; k++) begin
            b = first + 8'(k);
            wbeat_data[k] = {64{b}};
            wbeat_strb[k] = strb;
        end
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        rst = 1'b1;
        sr_req_valid = 1'b0; sr_req_is_write = 1'b0; sr_req_addr = '0; sr_req_data = '0;
        axi_awvalid = 1'b0; axi_awid = '0; axi_awaddr = '0; axi_awlen = '0;
        axi_awsize = 3'd6; axi_awburst = 2'b01;
        axi_wvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0;
        axi_bready = 1'b0;
        axi_arvalid = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0;
        axi_arsize = 3'd6; axi_arburst = 2'b01;
        axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        fork
            monitor();
        join_none

        // Single-beat write then read
        fill_beats(8'hA5, {64{1'b1}});
        wbeat_data[0] = {64{8'hA5}};
        axi_write(64'h40, 16'd5, 0, 0, -1);
        axi_read(64'h40, 16'd7, 0, 0, 0);
        check("t1_rdata_lit", got_r[0], {64{8'hA5}});

        // Burst with a partially strobed beat over zeroed words
        fill_beats(8'h00, {64{1'b1}});
        for (int k = 0; k < 4; k++) wbeat_data[k] = '0;
        axi_write(64'h0, 16'd1, 3, 0, -1);
        fill_beats(8'h01, {64{1'b1}});
        wbeat_strb[2] = 64'h0000_0000_0000_FFFF;
        axi_write(64'h0, 16'd2, 3, 0, -1);
        axi_read(64'h0, 16'd3, 3, 0, 0);
        check("t2_beat0_lit", got_r[0], {64{8'h01}});
        check("t2_beat1_lit", got_r[1], {64{8'h02}});
        check("t2_beat2_lit", got_r[2], {{48{8'h00}}, {16{8'h03}}});
        check("t2_beat3_lit", got_r[3], {64{8'h04}});

        // Wrap from the last word to word 0
        fill_beats(8'hC1, {64{1'b1}});
        axi_write(64'hFFC0, 16'd2, 1, 0, -1);
        axi_read(64'h0, 16'd4, 0, 0, 0);
        check("t3_wrap_lit", got_r[0], {64{8'hC2}});
        axi_read(64'hFFC0, 16'd6, 1, 0, 0);
        check("t3_last_word_lit", got_r[0], {64{8'hC1}});
        check("t3_wrap_read_lit", got_r[1], {64{8'hC2}});

        // Backpressure on B and R
        fill_beats(8'hD0, {64{1'b1}});
        axi_write(64'h100, 16'h000B, 2, 3, -1);
        axi_read(64'h0, 16'h000C, 3, 2, 5);
        check("t4_beat2_lit", got_r[2], {{48{8'h00}}, {16{8'h03}}});

        // Burst counters and SoftReg access
        sr_write(32'h20);
        model_wr_bursts = 0; model_rd_bursts = 0;
        fill_beats(8'h50, {64{1'b1}});
        axi_write(64'h400, 16'd10, 0, 0, -1);
        axi_write(64'h440, 16'd11, 0, 0, -1);
        axi_write(64'h480, 16'd12, 1, 0, -1);
        axi_read(64'h400, 16'd13, 0, 0, 0);
        axi_read(64'h480, 16'd14, 1, 0, 0);
        check("t5_model_wr_lit", 64'(model_wr_bursts), 64'd3);
        check("t5_model_rd_lit", 64'(model_rd_bursts), 64'd2);
        sr_read("t5_sr_wr", 32'h20, 1'b1, 64'(model_wr_bursts));
        sr_read("t5_sr_rd", 32'h28, 1'b1, 64'(model_rd_bursts));
        sr_read("t5_sr_other", 32'h30, 1'b0, 64'd0);
        sr_write(32'h20);
        model_wr_bursts = 0; model_rd_bursts = 0;
        sr_read("t5_sr_wr_clr", 32'h20, 1'b1, 64'd0);
        sr_read("t5_sr_rd_clr", 32'h28, 1'b1, 64'd0);

        // Reset in the middle of a len-7 write
        axi_write(64'h400, 16'd20, 0, 0, -1);
        fill_beats(8'hE0, {64{1'b1}});
        axi_write(64'h200, 16'd9, 7, 0, 2);
        sr_read("t6_sr_wr_after_rst", 32'h20, 1'b1, 64'd0);
        axi_read(64'h200, 16'd1, 1, 0, 0);
        check("t6_beat0_lit", got_r[0], {64{8'hE0}});
        check("t6_beat1_lit", got_r[1], {64{8'hE1}});

        repeat (4) @(negedge clk);
        check("end_r_queue_empty", 32'(exp_r_data.size()), 32'd0);
        check("end_b_queue_empty", 32'(exp_b_id.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
